// File: rtl/rgb_frame_loader_if.sv
// Pixel stream and committed-frame interface of rgb_frame_loader.
//   sof        start-of-frame strobe (one cycle)
//   din        pixel byte, transferred when din_valid && din_ready
//   din_valid  din is valid this cycle
//   din_ready  loader accepts din this cycle
//   bright     global brightness, sampled with every byte
//   rgb_data_01..08  committed frame, 8 LEDs (24 bytes) per bus, MSB of a byte at the lowest index
//   frame_done one-cycle pulse on commit
//   frame_err  one-cycle pulse when a partial frame is aborted
//   busy       frame loading or committing
interface rgb_frame_loader_if;
    logic         sof;
    logic [7:0]   din;
    logic         din_valid;
    logic         din_ready;
    logic [7:0]   bright;
    logic [0:191] rgb_data_01;
    logic [0:191] rgb_data_02;
    logic [0:191] rgb_data_03;
    logic [0:191] rgb_data_04;
    logic [0:191] rgb_data_05;
    logic [0:191] rgb_data_06;
    logic [0:191] rgb_data_07;
    logic [0:191] rgb_data_08;
    logic         frame_done;
    logic         frame_err;
    logic         busy;

    modport master (
        output sof, din, din_valid, bright,
        input  din_ready, rgb_data_01, rgb_data_02, rgb_data_03, rgb_data_04,
               rgb_data_05, rgb_data_06, rgb_data_07, rgb_data_08,
               frame_done, frame_err, busy
    );

    modport slave (
        input  sof, din, din_valid, bright,
        output din_ready, rgb_data_01, rgb_data_02, rgb_data_03, rgb_data_04,
               rgb_data_05, rgb_data_06, rgb_data_07, rgb_data_08,
               frame_done, frame_err, busy
    );
endinterface

// File: rtl/rgb_frame_loader.sv
// Upstream stage of the 64-LED WS2812B driver. Collects 192 pixel bytes
// (G,R,B per LED) into a shadow buffer through a one-register brightness
// scaling stage and commits the complete frame to eight 192-bit buses at once.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rgb_frame_loader_if.slave (stream in, committed frame and flags out)
//
// state  | meaning
// IDLE   | waiting for SOF; accepted bytes are dropped
// LOAD   | collecting bytes 0..191, idle timer running
// COMMIT | one cycle after byte 191; stream stalled while the last byte lands
module rgb_frame_loader #(
    parameter int TIMEOUT_CYCLES = 1200000,
    parameter bit SCALE_EN       = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    rgb_frame_loader_if.slave bus
);
    localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMR_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     LAST_BYTE = 8'd191;

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t        state;
    logic [7:0]    ptr;
    logic [TW-1:0] tmr;
    logic          commit_pend;
    logic          din_ready_q;
    logic          busy_q;
    logic          frame_done_q;
    logic          frame_err_q;

    logic          pipe_valid;
    logic [7:0]    pipe_data;
    logic [7:0]    pipe_idx;

    logic [7:0]    shadow [0:191];
    logic [0:191]  out_q  [0:7];

    logic          xfer;
    logic [15:0]   prod;
    logic [7:0]    scaled;

    assign xfer   = bus.din_valid & din_ready_q;
    assign prod   = {8'd0, bus.din} * ({8'd0, bus.bright} + 16'd1);
    assign scaled = SCALE_EN ? 8'(prod >> 8) : bus.din;

    // Control FSM. The idle timer is a down-counter reloaded on every accepted
    // byte and on SOF; reaching zero with nothing accepted aborts the frame.
    // commit_pend delays the shadow->output copy by one cycle so the final
    // pipeline write has landed in the shadow before it is copied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            tmr          <= TMR_LOAD;
            commit_pend  <= 1'b0;
            din_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            pipe_valid   <= 1'b0;
            pipe_data    <= '0;
            pipe_idx     <= '0;
        end else begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            pipe_valid   <= 1'b0;

            if (commit_pend) begin
                commit_pend  <= 1'b0;
                frame_done_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    din_ready_q <= 1'b1;
                    if (bus.sof) begin
                        state  <= LOAD;
                        busy_q <= 1'b1;
                        tmr    <= TMR_LOAD;
                        if (xfer) begin
                            pipe_valid <= 1'b1;
                            pipe_data  <= scaled;
                            pipe_idx   <= 8'd0;
                            ptr        <= 8'd1;
                        end else begin
                            ptr <= 8'd0;
                        end
                    end
                end

                LOAD: begin
                    if (bus.sof) begin
                        // restart: the byte in this cycle (if any) is byte 0
                        if (ptr != 8'd0) frame_err_q <= 1'b1;
                        tmr <= TMR_LOAD;
                        if (xfer) begin
                            pipe_valid <= 1'b1;
                            pipe_data  <= scaled;
                            pipe_idx   <= 8'd0;
                            ptr        <= 8'd1;
                        end else begin
                            ptr <= 8'd0;
                        end
                    end else if (xfer) begin
                        pipe_valid <= 1'b1;
                        pipe_data  <= scaled;
                        pipe_idx   <= ptr;
                        tmr        <= TMR_LOAD;
                        if (ptr == LAST_BYTE) begin
                            state       <= COMMIT;
                            ptr         <= 8'd0;
                            din_ready_q <= 1'b0;
                        end else begin
                            ptr <= ptr + 8'd1;
                        end
                    end else if (tmr == '0) begin
                        state       <= IDLE;
                        ptr         <= 8'd0;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end

                COMMIT: begin
                    state       <= IDLE;
                    commit_pend <= 1'b1;
                    din_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    din_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 192; k++) shadow[k] <= '0;
        end else if (pipe_valid) begin
            shadow[pipe_idx] <= pipe_data;
        end
    end

    // Byte k lands on bus k/24, byte MSB at the lowest bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 8; j++) out_q[j] <= '0;
        end else if (commit_pend) begin
            for (int k = 0; k < 192; k++) out_q[k / 24][(k % 24) * 8 +: 8] <= shadow[k];
        end
    end

    assign bus.din_ready   = din_ready_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.rgb_data_01 = out_q[0];
    assign bus.rgb_data_02 = out_q[1];
    assign bus.rgb_data_03 = out_q[2];
    assign bus.rgb_data_04 = out_q[3];
    assign bus.rgb_data_05 = out_q[4];
    assign bus.rgb_data_06 = out_q[5];
    assign bus.rgb_data_07 = out_q[6];
    assign bus.rgb_data_08 = out_q[7];
endmodule
